// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer between the EX/MEM register and a multi-cycle
// memory: one req/ack transaction per instruction, pipeline stall, sticky timeout.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        timeout_o
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_c;
  logic          access;

  assign access = MemRead_i | MemWrite_i;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          stall_c = 1'b1;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          // A simultaneous read+write request is served as a store.
          we_d    = MemWrite_i;
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = BUSY;
        end
      end

      BUSY: begin
        stall_c = 1'b1;
        if (mem_ack_i) begin
          if (!we_q) begin
            rdata_d = mem_rdata_i;
          end
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          rdata_d   = 32'h0;
          req_d     = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // One unstalled cycle lets the served instruction leave EX/MEM before
      // the controller looks at MemRead/MemWrite again.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign stall_o     = start_i & stall_c;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: transaction-level model checked every cycle,
// plus hand-computed literal expectations at key cycles of each scenario.
module tb_dmem_access_ctrl;

  localparam int TO = 64;

  logic        clk_i = 1'b0;
  logic        start_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        timeout_o;

  dmem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk_i      (clk_i),
    .start_i    (start_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .stall_o    (stall_o),
    .rdata_o    (rdata_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Transaction model: an instruction either waits for service, has a request
  // outstanding (counting unanswered cycles), or is being let go by the pipeline.
  logic        m_pend, m_skip, m_we, m_to;
  int          m_waited;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      m_pend <= 1'b0; m_skip <= 1'b0; m_we <= 1'b0; m_to <= 1'b0;
      m_waited <= 0; m_addr <= 32'h0; m_wdata <= 32'h0; m_rdata <= 32'h0;
    end else if (m_skip) begin
      m_skip <= 1'b0;
    end else if (m_pend) begin
      if (mem_ack_i) begin
        m_pend <= 1'b0;
        m_skip <= 1'b1;
        if (!m_we) m_rdata <= mem_rdata_i;
      end else if (m_waited + 1 >= TO) begin
        m_pend  <= 1'b0;
        m_skip  <= 1'b1;
        m_to    <= 1'b1;
        m_rdata <= 32'h0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (MemRead_i || MemWrite_i) begin
      m_pend   <= 1'b1;
      m_waited <= 0;
      m_addr   <= addr_i;
      m_wdata  <= wdata_i;
      m_we     <= MemWrite_i;
    end
  end

  // Literal expectations posted by the stimulus for the current cycle.
  localparam int S_REQ = 0, S_WE = 1, S_ADDR = 2, S_WDATA = 3, S_STALL = 4,
                 S_RDATA = 5, S_TO = 6, S_RISES = 7;
  int          lit_sel [8];
  logic [31:0] lit_val [8];
  int          lit_n = 0;
  bit          cmp_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic string sel_name(input int s);
    case (s)
      S_REQ:   return "lit_req";
      S_WE:    return "lit_we";
      S_ADDR:  return "lit_addr";
      S_WDATA: return "lit_wdata";
      S_STALL: return "lit_stall";
      S_RDATA: return "lit_rdata";
      S_TO:    return "lit_timeout";
      default: return "lit_req_count";
    endcase
  endfunction

  function automatic logic [31:0] sel_val(input int s);
    case (s)
      S_REQ:   return 32'(mem_req_o);
      S_WE:    return 32'(mem_we_o);
      S_ADDR:  return mem_addr_o;
      S_WDATA: return mem_wdata_o;
      S_STALL: return 32'(stall_o);
      S_RDATA: return rdata_o;
      S_TO:    return 32'(timeout_o);
      default: return 32'(req_rises);
    endcase
  endfunction

  initial begin
    logic stall_exp;
    forever begin
      @(negedge clk_i or negedge start_i);
      #1;
      if (cmp_en) begin
        stall_exp = start_i && (m_pend || (!m_skip && (MemRead_i || MemWrite_i)));
        chk("req",     32'(mem_req_o), 32'(m_pend));
        chk("we",      32'(mem_we_o),  32'(m_we));
        chk("addr",    mem_addr_o,     m_addr);
        chk("wdata",   mem_wdata_o,    m_wdata);
        chk("stall",   32'(stall_o),   32'(stall_exp));
        chk("rdata",   rdata_o,        m_rdata);
        chk("timeout", 32'(timeout_o), 32'(m_to));
        if (mem_req_o && !req_prev) req_rises++;
        req_prev = mem_req_o;
        for (int i = 0; i < lit_n; i++)
          chk(sel_name(lit_sel[i]), sel_val(lit_sel[i]), lit_val[i]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
    lit_n = 0;
  endtask

  task automatic lit(input int s, input logic [31:0] v);
    lit_sel[lit_n] = s;
    lit_val[lit_n] = v;
    lit_n++;
  endtask

  task automatic quiet();
    MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  initial begin
    start_i = 1'b0;
    quiet();
    addr_i = 32'h0; wdata_i = 32'h0; mem_rdata_i = 32'h0;
    cyc(); cyc();
    cmp_en = 1'b1;
    // Reset state
    cyc(); lit(S_REQ, 0); lit(S_STALL, 0); lit(S_TO, 0); lit(S_RDATA, 0); lit(S_ADDR, 0);
    cyc(); start_i = 1'b1;
    cyc(); lit(S_REQ, 0);

    // Load, ack in the first request cycle
    cyc(); MemRead_i = 1'b1; addr_i = 32'h20; lit(S_STALL, 1); lit(S_REQ, 0);
    cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
           lit(S_REQ, 1); lit(S_WE, 0); lit(S_ADDR, 32'h20); lit(S_STALL, 1);
    cyc(); mem_ack_i = 1'b0; lit(S_RDATA, 32'h12345678); lit(S_STALL, 0); lit(S_REQ, 0);
    cyc(); quiet(); lit(S_STALL, 0); lit(S_REQ, 0);

    // Store, ack in cycle 3
    cyc(); MemWrite_i = 1'b1; addr_i = 32'h10; wdata_i = 32'hDEADBEEF; lit(S_STALL, 1);
    cyc(); lit(S_REQ, 1); lit(S_WE, 1); lit(S_WDATA, 32'hDEADBEEF);
    cyc(); lit(S_REQ, 1); lit(S_STALL, 1);
    cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0; lit(S_REQ, 1); lit(S_STALL, 1);
    cyc(); mem_ack_i = 1'b0; lit(S_STALL, 0); lit(S_REQ, 0); lit(S_RDATA, 32'h12345678);
    cyc(); quiet(); lit(S_RISES, 2);

    // Back-to-back load then store
    cyc(); MemRead_i = 1'b1; addr_i = 32'h30;
    cyc();
    cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5;
    cyc(); mem_ack_i = 1'b0; lit(S_RDATA, 32'hA5A5A5A5); lit(S_STALL, 0);
    cyc(); MemRead_i = 1'b0; MemWrite_i = 1'b1; addr_i = 32'h34; wdata_i = 32'h11112222;
           lit(S_STALL, 1); lit(S_REQ, 0);
    cyc(); mem_ack_i = 1'b1; lit(S_REQ, 1); lit(S_WE, 1); lit(S_ADDR, 32'h34);
    cyc(); mem_ack_i = 1'b0; lit(S_REQ, 0); lit(S_RDATA, 32'hA5A5A5A5);
    cyc(); quiet(); lit(S_RISES, 4);

    // Hung load: abort after TO unanswered request cycles
    cyc(); MemRead_i = 1'b1; addr_i = 32'h40;
    for (int k = 1; k <= TO; k++) begin
      cyc();
      if (k == TO) begin
        lit(S_REQ, 1); lit(S_TO, 0); lit(S_STALL, 1);
      end
    end
    cyc(); lit(S_TO, 1); lit(S_RDATA, 0); lit(S_REQ, 0); lit(S_STALL, 0);
    cyc(); quiet(); lit(S_RISES, 5); lit(S_TO, 1);
    // Later load still served; timeout stays set
    cyc(); MemRead_i = 1'b1; addr_i = 32'h44;
    cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
    cyc(); mem_ack_i = 1'b0; lit(S_RDATA, 32'h0BADF00D); lit(S_TO, 1);
    cyc(); quiet();

    // Read and write together -> store; stray acks outside a request
    cyc(); MemRead_i = 1'b1; MemWrite_i = 1'b1; addr_i = 32'h50; wdata_i = 32'hCAFEF00D;
    cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777; lit(S_WE, 1); lit(S_REQ, 1);
    cyc(); lit(S_RDATA, 32'h0BADF00D);
    cyc(); MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_rdata_i = 32'h99999999;
    cyc(); lit(S_REQ, 0); lit(S_STALL, 0); lit(S_RISES, 7);
    cyc(); mem_ack_i = 1'b0; lit(S_RDATA, 32'h0BADF00D);

    // Reset in the middle of a request
    cyc(); MemRead_i = 1'b1; addr_i = 32'h60;
    cyc(); lit(S_REQ, 1);
    cyc(); start_i = 1'b0;
           lit(S_REQ, 0); lit(S_STALL, 0); lit(S_TO, 0); lit(S_RDATA, 0); lit(S_ADDR, 0);
    cyc(); start_i = 1'b1; MemRead_i = 1'b0; lit(S_REQ, 0); lit(S_STALL, 0);
    cyc(); lit(S_REQ, 0);
    cyc(); lit(S_REQ, 0); lit(S_RISES, 8);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
